dmem_stream_reader: RTL and testbench

- Sequential read engine that sits directly upstream of dmem's read-only ports (c–h). Each instance drives one such port.
- Fetches a contiguous run of 32-bit words, starting at a base word address, from the dual-port BlockRAM.
- Buffers the returned words in a small FIFO and presents them downstream on a valid/ready stream, e.g. to vertex fetch or rasterizer stages.
- Absorbs the fixed 1-cycle BRAM read latency and applies credit-based backpressure.

---
 rtl/dmem_stream_reader.sv | 136 +++++++++++++
 tb/tb_dmem_stream_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader: fetches a contiguous run of words from one read-only dmem
// port and presents them on a valid/ready stream through a small show-ahead FIFO.
module dmem_stream_reader #(
  parameter int data_width = 32,
  parameter int addr_width = 15,
  parameter int len_width  = 16,
  parameter int fifo_depth = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_START,
  input  logic [addr_width-1:0] i_BASE_ADDR,
  input  logic [len_width-1:0]  i_LEN,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_MEM_EN,
  output logic [addr_width-1:0] o_MEM_ADDR,
  input  logic [data_width-1:0] i_MEM_RDATA,
  output logic                  o_VALID,
  output logic [data_width-1:0] o_DATA,
  output logic                  o_LAST,
  input  logic                  i_READY
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam logic [len_width-1:0]  len_one   = len_width'(1);
  localparam logic [addr_width-1:0] addr_one  = addr_width'(1);
  localparam logic [ptr_w-1:0]      ptr_one   = ptr_w'(1);
  localparam logic [ptr_w:0]        cnt_one   = (ptr_w + 1)'(1);
  localparam logic [ptr_w+1:0]      depth_lim = (ptr_w + 2)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t                state, state_nxt;
  logic [len_width-1:0]  len_q, issued, popped;
  logic [addr_width-1:0] addr_cnt;
  logic                  rd_vld_p1;
  logic [data_width-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr, rd_ptr;
  logic [ptr_w:0]        count;
  logic [ptr_w+1:0]      occupancy;
  logic                  issue, push, pop, start_ok;

  // Every word that could still land in the FIFO: stored, on the BRAM address
  // port this cycle, and returning this cycle. Counting pops would be optimistic.
  assign occupancy = (ptr_w + 2)'(count) + (ptr_w + 2)'(o_MEM_EN) + (ptr_w + 2)'(rd_vld_p1);
  assign start_ok  = (state == IDLE) && i_START && (i_LEN != '0);
  assign push      = rd_vld_p1;
  assign pop       = o_VALID && i_READY;

  assign o_VALID = (count != '0);
  assign o_DATA  = o_VALID ? fifo_mem[rd_ptr] : '0;
  assign o_LAST  = o_VALID && (popped == len_q - len_one);
  assign o_BUSY  = (state == FETCH) || (state == DRAIN);
  assign o_DONE  = (state == FIN);

  // State register
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and read-issue decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_START) state_nxt = (i_LEN == '0) ? FIN : FETCH;
      end
      FETCH: begin
        if ((issued < len_q) && (occupancy < depth_lim)) begin
          issue = 1'b1;
          if (issued == len_q - len_one) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && o_LAST) state_nxt = FIN;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer bookkeeping and the registered BRAM request (stage p0 -> p1)
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      len_q      <= '0;
      addr_cnt   <= '0;
      issued     <= '0;
      popped     <= '0;
      o_MEM_EN   <= 1'b0;
      o_MEM_ADDR <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      o_MEM_EN  <= issue;
      rd_vld_p1 <= o_MEM_EN;
      if (start_ok) begin
        len_q    <= i_LEN;
        addr_cnt <= i_BASE_ADDR;
        issued   <= '0;
        popped   <= '0;
      end else begin
        if (issue) begin
          issued     <= issued + len_one;
          addr_cnt   <= addr_cnt + addr_one;
          o_MEM_ADDR <= addr_cnt;
        end
        if (pop) popped <= popped + len_one;
      end
    end
  end

  // FIFO control: pointers and occupancy
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
      case ({push, pop})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: returning BRAM word captured at the end of its valid cycle
  always_ff @(posedge i_CLK) begin
    if (push) fifo_mem[wr_ptr] <= i_MEM_RDATA;
  end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Directed bench for dmem_stream_reader with a 1-cycle-latency BRAM model.
module tb_dmem_stream_reader;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, ready;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, mem_en, valid, last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, data;

  dmem_stream_reader #(.data_width(DW), .addr_width(AW), .len_width(LW), .fifo_depth(4)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_START(start), .i_BASE_ADDR(base), .i_LEN(len),
    .o_BUSY(busy), .o_DONE(done), .o_MEM_EN(mem_en), .o_MEM_ADDR(mem_addr),
    .i_MEM_RDATA(mem_rdata), .o_VALID(valid), .o_DATA(data), .o_LAST(last), .i_READY(ready)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, data valid the cycle after the enable
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_en) mem_rdata <= bram[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, sampling on the falling edge
  int            cyc = 0, rd_live = 0, bt_live = 0;
  int            en_cnt = 0, done_cnt = 0, valid_cnt = 0, hold_bad = 0, done_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] beat_q[$];
  logic          last_q[$];
  int            beat_cyc_q[$];
  logic [AW-1:0] addr_q[$];
  int            outst_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd_live = 0; bt_live = 0; prev_stall = 1'b0;
    end else begin
      if (mem_en) begin
        en_cnt++; rd_live++;
        addr_q.push_back(mem_addr);
        outst_q.push_back(rd_live - bt_live);
      end
      if (valid) valid_cnt++;
      if (prev_stall && valid && (data !== prev_data)) hold_bad++;
      if (valid && ready) begin
        beat_q.push_back(data); last_q.push_back(last); beat_cyc_q.push_back(cyc); bt_live++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  // Snapshots taken at the start of each scenario
  int b0, a0, o0, en0, d0, v0, h0, start_cyc;
  logic [31:0] exp_data [8];

  task automatic snap();
    b0 = beat_q.size(); a0 = addr_q.size(); o0 = outst_q.size();
    en0 = en_cnt; d0 = done_cnt; v0 = valid_cnt; h0 = hold_bad;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l);
    base = b; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc + 1;
  endtask

  task automatic run_until_done(input string tag, input int budget, input logic [31:0] rpat);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      ready = rpat[k % 32];
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    check_val({tag, "_done_seen"}, 32'(seen), 1);
    tick();
    ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int n);
    int nl = 0;
    check_val({tag, "_nbeats"}, beat_q.size() - b0, n);
    for (int i = 0; i < n; i++) begin
      if (b0 + i < beat_q.size()) begin
        check_val({tag, "_data"}, beat_q[b0 + i], exp_data[i]);
        if (last_q[b0 + i]) nl++;
      end
    end
    check_val({tag, "_nlast"}, nl, 1);
    if (b0 + n <= beat_q.size()) check_val({tag, "_last_pos"}, 32'(last_q[b0 + n - 1]), 1);
  endtask

  function automatic int max_outst();
    int m = 0;
    for (int i = o0; i < outst_q.size(); i++) if (outst_q[i] > m) m = outst_q[i];
    return m;
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) bram[100 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 6; i++) bram[200 + i] = 32'h600 + 32'(i);
    bram[15'h7FFE] = 32'd1; bram[15'h7FFF] = 32'd2; bram[0] = 32'd3; bram[1] = 32'd4;
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; base = '0; len = '0;
    tick(); tick();

    // Reset state
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_mem_en", 32'(mem_en), 0);
    check_val("rst_mem_addr", 32'(mem_addr), 0);
    check_val("rst_valid", 32'(valid), 0);
    check_val("rst_data", data, 0);
    check_val("rst_last", 32'(last), 0);
    rst_n = 1'b1;
    tick();

    // Single burst, no backpressure
    snap();
    for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + 32'(i);
    start_xfer(15'd100, 16'd8);
    check_val("s1_busy", 32'(busy), 1);
    run_until_done("s1", 100, 32'hFFFF_FFFF);
    check_stream("s1", 8);
    if (b0 + 8 <= beat_q.size()) begin
      check_val("s1_first_lat", beat_cyc_q[b0] - start_cyc, 3);
      check_val("s1_back2back", beat_cyc_q[b0 + 7] - beat_cyc_q[b0], 7);
      check_val("s1_done_after_last", done_cyc - beat_cyc_q[b0 + 7], 1);
    end
    check_val("s1_en_cycles", en_cnt - en0, 8);
    check_val("s1_done_pulses", done_cnt - d0, 1);
    check_val("s1_busy_after", 32'(busy), 0);

    // Backpressure, ready pattern 1,0,0,1,1,0,1,0,...
    snap();
    start_xfer(15'd100, 16'd8);
    run_until_done("s2", 300, 32'h5A5B_3C59);
    check_stream("s2", 8);
    check_val("s2_hold", hold_bad - h0, 0);
    check_val("s2_outst_le4", 32'(max_outst() <= 4), 1);
    check_val("s2_en_cycles", en_cnt - en0, 8);
    check_val("s2_done_pulses", done_cnt - d0, 1);

    // Zero length: done in the cycle entered by the accepting edge
    snap();
    start_xfer(15'd300, 16'd0);
    check_val("s3_done", 32'(done), 1);
    check_val("s3_busy", 32'(busy), 0);
    tick();
    check_val("s3_done_clear", 32'(done), 0);
    tick();
    check_val("s3_en_cycles", en_cnt - en0, 0);
    check_val("s3_valid_cycles", valid_cnt - v0, 0);
    check_val("s3_done_pulses", done_cnt - d0, 1);

    // Address wrap
    snap();
    exp_data[0] = 1; exp_data[1] = 2; exp_data[2] = 3; exp_data[3] = 4;
    start_xfer(15'h7FFE, 16'd4);
    run_until_done("s4", 60, 32'hFFFF_FFFF);
    check_stream("s4", 4);
    check_val("s4_naddr", addr_q.size() - a0, 4);
    if (a0 + 4 <= addr_q.size()) begin
      check_val("s4_addr0", 32'(addr_q[a0]), 32'h7FFE);
      check_val("s4_addr1", 32'(addr_q[a0 + 1]), 32'h7FFF);
      check_val("s4_addr2", 32'(addr_q[a0 + 2]), 32'h0000);
      check_val("s4_addr3", 32'(addr_q[a0 + 3]), 32'h0001);
    end

    // Long stall: four reads fill the FIFO, then issue stops
    snap();
    for (int i = 0; i < 6; i++) exp_data[i] = 32'h600 + 32'(i);
    ready = 1'b0;
    start_xfer(15'd200, 16'd6);
    for (int k = 0; k < 20; k++) tick();
    check_val("s6_reads_stalled", en_cnt - en0, 4);
    check_val("s6_mem_en_idle", 32'(mem_en), 0);
    check_val("s6_valid", 32'(valid), 1);
    check_val("s6_head", data, 32'h600);
    check_val("s6_max_outst", max_outst(), 4);
    check_val("s6_no_beats", beat_q.size() - b0, 0);
    run_until_done("s6", 60, 32'hFFFF_FFFF);
    check_stream("s6", 6);
    check_val("s6_en_cycles", en_cnt - en0, 6);

    // Start while busy, then reset mid-transfer
    snap();
    ready = 1'b1;
    start_xfer(15'd100, 16'd8);
    for (int k = 0; k < 40 && (beat_q.size() - b0) < 2; k++) tick();
    base = 15'd0; len = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && (beat_q.size() - b0) < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    check_val("s5_rst_busy", 32'(busy), 0);
    check_val("s5_rst_done", 32'(done), 0);
    check_val("s5_rst_mem_en", 32'(mem_en), 0);
    check_val("s5_rst_mem_addr", 32'(mem_addr), 0);
    check_val("s5_rst_valid", 32'(valid), 0);
    check_val("s5_rst_data", data, 0);
    check_val("s5_rst_last", 32'(last), 0);
    tick(); tick();
    check_val("s5_nbeats", beat_q.size() - b0, 5);
    for (int i = 0; i < 5; i++)
      if (b0 + i < beat_q.size()) check_val("s5_data", beat_q[b0 + i], 32'hA0 + 32'(i));
    for (int i = a0; i < addr_q.size(); i++)
      check_val("s5_addr", 32'(addr_q[i]), 32'd100 + 32'(i - a0));
    check_val("s5_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    tick();
    snap();
    exp_data[0] = 3; exp_data[1] = 4;
    start_xfer(15'd0, 16'd2);
    run_until_done("s5b", 60, 32'hFFFF_FFFF);
    check_stream("s5b", 2);
    check_val("s5b_done_pulses", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
